// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the multi-channel LFSR random source.
package lfsr_pkg;

    typedef enum logic [1:0] {StIdle, StDraw, StResp} state_e;

    // One-hot bit for a 1-based tap position.
    function automatic logic [31:0] tap_bit(int unsigned n);
        return 32'(1) << (n - 1);
    endfunction

    // Maximal-length XNOR tap mask, bit (n-1) represents tap n.
    function automatic logic [31:0] taps(int unsigned n);
        logic [31:0] t;
        t = '0;
        case (n)
            3:  t = tap_bit(3)  | tap_bit(2);
            4:  t = tap_bit(4)  | tap_bit(3);
            5:  t = tap_bit(5)  | tap_bit(3);
            6:  t = tap_bit(6)  | tap_bit(5);
            7:  t = tap_bit(7)  | tap_bit(6);
            8:  t = tap_bit(8)  | tap_bit(6)  | tap_bit(5)  | tap_bit(4);
            9:  t = tap_bit(9)  | tap_bit(5);
            10: t = tap_bit(10) | tap_bit(7);
            11: t = tap_bit(11) | tap_bit(9);
            12: t = tap_bit(12) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
            13: t = tap_bit(13) | tap_bit(4)  | tap_bit(3)  | tap_bit(1);
            14: t = tap_bit(14) | tap_bit(5)  | tap_bit(3)  | tap_bit(1);
            15: t = tap_bit(15) | tap_bit(14);
            16: t = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
            17: t = tap_bit(17) | tap_bit(14);
            18: t = tap_bit(18) | tap_bit(11);
            19: t = tap_bit(19) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
            20: t = tap_bit(20) | tap_bit(17);
            21: t = tap_bit(21) | tap_bit(19);
            22: t = tap_bit(22) | tap_bit(21);
            23: t = tap_bit(23) | tap_bit(18);
            24: t = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
            25: t = tap_bit(25) | tap_bit(22);
            26: t = tap_bit(26) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
            27: t = tap_bit(27) | tap_bit(5)  | tap_bit(2)  | tap_bit(1);
            28: t = tap_bit(28) | tap_bit(25);
            29: t = tap_bit(29) | tap_bit(27);
            30: t = tap_bit(30) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
            31: t = tap_bit(31) | tap_bit(28);
            32: t = tap_bit(32) | tap_bit(22) | tap_bit(2)  | tap_bit(1);
            default: t = '0;
        endcase
        return t;
    endfunction

    // Smallest 2^n-1 covering range-1; range 0 means the full output width.
    function automatic logic [31:0] cover_mask(logic [31:0] range_v);
        logic [31:0] m;
        logic [31:0] v;
        if (range_v == '0) begin
            return '1;
        end
        v = range_v - 32'd1;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (m < v) begin
                m = {m[30:0], 1'b1};
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/lfsr_rng_if.sv
// Request/response handshake bundle between a consumer and lfsr_rng.
interface lfsr_rng_if #(
    parameter int unsigned OUT_BITS = 8,
    parameter int unsigned CH_W     = 2
);
    logic                i_Req_Valid;
    logic                o_Req_Ready;
    logic [CH_W-1:0]     i_Req_Ch;
    logic [OUT_BITS-1:0] i_Range;
    logic                o_Rsp_Valid;
    logic                i_Rsp_Ready;
    logic [OUT_BITS-1:0] o_Rsp_Data;
    logic [CH_W-1:0]     o_Rsp_Ch;

    modport master (
        output i_Req_Valid, i_Req_Ch, i_Range, i_Rsp_Ready,
        input  o_Req_Ready, o_Rsp_Valid, o_Rsp_Data, o_Rsp_Ch
    );

    modport slave (
        input  i_Req_Valid, i_Req_Ch, i_Range, i_Rsp_Ready,
        output o_Req_Ready, o_Rsp_Valid, o_Rsp_Data, o_Rsp_Ch
    );
endinterface

// File: rtl/lfsr_core.sv
// One LFSR channel: XNOR step, rotated seed load with lock-up substitution, wrap detect.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned NUM_BITS = 16,
    parameter int unsigned ROT      = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                step_i,
    input  logic                load_i,
    input  logic [NUM_BITS-1:0] seed_i,
    output logic [NUM_BITS-1:0] state_o,
    output logic                wrap_o
);
    localparam logic [NUM_BITS-1:0] TapMask = NUM_BITS'(taps(NUM_BITS));
    localparam int unsigned         RotAmt  = ROT % NUM_BITS;

    logic [NUM_BITS-1:0] state_q, seed_q;
    logic                wrap_q;
    logic [NUM_BITS-1:0] rot_seed, load_val, next_state;
    logic                fb;

    // Rotated seed (shift by NUM_BITS yields 0, so RotAmt=0 passes through) and step value.
    always_comb begin
        rot_seed   = (seed_i << RotAmt) | (seed_i >> (NUM_BITS - RotAmt));
        load_val   = (rot_seed == '1) ? '0 : rot_seed;
        fb         = ~^(state_q & TapMask);
        next_state = {state_q[NUM_BITS-2:0], fb};
    end

    // Load beats step; wrap only flags a step that lands back on the stored seed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= '0;
            seed_q  <= '0;
            wrap_q  <= 1'b0;
        end else if (load_i) begin
            state_q <= load_val;
            seed_q  <= load_val;
            wrap_q  <= 1'b0;
        end else if (step_i) begin
            state_q <= next_state;
            wrap_q  <= (next_state == seed_q);
        end else begin
            wrap_q  <= 1'b0;
        end
    end

    assign state_o = state_q;
    assign wrap_o  = wrap_q;
endmodule

// File: rtl/lfsr_rng.sv
// Multi-channel LFSR random source with bounded mask-and-reject draws.
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int unsigned NUM_BITS = 16,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned OUT_BITS = 8
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_n,
    input  logic                       i_Enable,
    input  logic                       i_Seed_DV,
    input  logic [NUM_BITS-1:0]        i_Seed_Data,
    lfsr_rng_if.slave                  bus,
    output logic [NUM_CH*NUM_BITS-1:0] o_LFSR_Data,
    output logic [NUM_CH-1:0]          o_Wrap
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e              state_q;
    logic                req_ready_q, rsp_valid_q;
    logic [OUT_BITS-1:0] rsp_data_q, range_q, mask_q;
    logic [CH_W-1:0]     rsp_ch_q, ch_q;

    logic [NUM_BITS-1:0] ch_state [NUM_CH];
    logic [OUT_BITS-1:0] sel_low, cand;
    logic                draw_step, accept;

    assign draw_step = (state_q == StDraw);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        lfsr_core #(
            .NUM_BITS (NUM_BITS),
            .ROT      (k)
        ) u_core (
            .clk_i   (i_Clk),
            .rst_ni  (i_Rst_n),
            .step_i  (i_Enable | (draw_step && (ch_q == CH_W'(k)))),
            .load_i  (i_Seed_DV),
            .seed_i  (i_Seed_Data),
            .state_o (ch_state[k]),
            .wrap_o  (o_Wrap[k])
        );
        assign o_LFSR_Data[k*NUM_BITS +: NUM_BITS] = ch_state[k];
    end

    // Candidate from the active channel; an out-of-range index reads as zero.
    always_comb begin
        sel_low = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == CH_W'(k)) begin
                sel_low = ch_state[k][OUT_BITS-1:0];
            end
        end
        cand   = sel_low & mask_q;
        accept = (range_q == '0) || (cand < range_q);
    end

    // Request FSM with registered handshake outputs; every DRAW cycle consumes one step.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ch_q    <= '0;
            ch_q        <= '0;
            range_q     <= '0;
            mask_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.i_Req_Valid && req_ready_q) begin
                        ch_q        <= bus.i_Req_Ch;
                        range_q     <= bus.i_Range;
                        mask_q      <= OUT_BITS'(cover_mask(32'(bus.i_Range)));
                        req_ready_q <= 1'b0;
                        state_q     <= StDraw;
                    end
                end
                StDraw: begin
                    if (accept) begin
                        rsp_data_q  <= cand;
                        rsp_ch_q    <= ch_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    if (bus.i_Rsp_Ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_Req_Ready = req_ready_q;
    assign bus.o_Rsp_Valid = rsp_valid_q;
    assign bus.o_Rsp_Data  = rsp_data_q;
    assign bus.o_Rsp_Ch    = rsp_ch_q;
endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng with 4-bit, 2-channel, 4-bit-output configuration.
module tb_lfsr_rng;
    localparam int unsigned NB = 4;
    localparam int unsigned NC = 2;
    localparam int unsigned OB = 4;
    localparam int unsigned CW = 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           seed_dv = 1'b0;
    logic [NB-1:0]  seed_data = '0;
    logic [NC*NB-1:0] lfsr_data;
    logic [NC-1:0]  wrap;

    lfsr_rng_if #(.OUT_BITS(OB), .CH_W(CW)) bus ();

    lfsr_rng #(
        .NUM_BITS (NB),
        .NUM_CH   (NC),
        .OUT_BITS (OB)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Enable    (enable),
        .i_Seed_DV   (seed_dv),
        .i_Seed_Data (seed_data),
        .bus         (bus),
        .o_LFSR_Data (lfsr_data),
        .o_Wrap      (wrap)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] seed;
        logic       ch;
        logic [3:0] range_v;
        logic [3:0] exp_ch0;
        logic [3:0] exp_ch1;
        logic [3:0] exp_data;
        logic [3:0] exp_final;
        int         exp_lat;
    } vec_t;

    vec_t vecs[10];
    logic [3:0] ref_seq[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seed(input logic [3:0] s);
        seed_data = s;
        seed_dv   = 1'b1;
        tick();
        seed_dv   = 1'b0;
    endtask

    task automatic send_req(input logic ch, input logic [3:0] r);
        bus.i_Req_Valid = 1'b1;
        bus.i_Req_Ch    = ch;
        bus.i_Range     = r;
        tick();
        bus.i_Req_Valid = 1'b0;
    endtask

    // Ticks until a response shows up; 0 means the bound expired.
    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (bus.o_Rsp_Valid && lat == 0) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic finish_rsp();
        bus.i_Rsp_Ready = 1'b1;
        tick();
        bus.i_Rsp_Ready = 1'b0;
        check("rsp_valid_after_hs", 32'(bus.o_Rsp_Valid), 32'd0);
        check("req_ready_after_hs", 32'(bus.o_Req_Ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [3:0] st;

        vecs[0] = '{4'hE, 1'b0, 4'd5,  4'hE, 4'hD, 4'h3, 4'h6, 3};
        vecs[1] = '{4'h0, 1'b0, 4'd0,  4'h0, 4'h0, 4'h0, 4'h1, 1};
        vecs[2] = '{4'h1, 1'b1, 4'd1,  4'h1, 4'h2, 4'h0, 4'h5, 1};
        vecs[3] = '{4'h9, 1'b0, 4'd3,  4'h9, 4'h3, 4'h1, 4'h2, 1};
        vecs[4] = '{4'h7, 1'b0, 4'd3,  4'h7, 4'hE, 4'h2, 4'hD, 2};
        vecs[5] = '{4'h4, 1'b1, 4'd2,  4'h4, 4'h8, 4'h0, 4'h0, 1};
        vecs[6] = '{4'h6, 1'b1, 4'd9,  4'h6, 4'hC, 4'h2, 4'h5, 3};
        vecs[7] = '{4'hF, 1'b0, 4'd0,  4'h0, 4'h0, 4'h0, 4'h1, 1};
        vecs[8] = '{4'hA, 1'b0, 4'd15, 4'hA, 4'h5, 4'hA, 4'h4, 1};
        vecs[9] = '{4'h8, 1'b1, 4'd4,  4'h8, 4'h1, 4'h1, 4'h3, 1};

        ref_seq = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC,
                    4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};

        bus.i_Req_Valid = 1'b0;
        bus.i_Req_Ch    = '0;
        bus.i_Range     = '0;
        bus.i_Rsp_Ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.o_Req_Ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.o_Rsp_Valid), 32'd0);
        check("rst_rsp_data",  32'(bus.o_Rsp_Data), 32'd0);
        check("rst_rsp_ch",    32'(bus.o_Rsp_Ch), 32'd0);
        check("rst_wrap",      32'(wrap), 32'd0);
        check("rst_lfsr",      32'(lfsr_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Free-run sequence from seed 0, wrap after the 15th step.
        load_seed(4'h0);
        enable = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("seq_ch0_%0d", i), 32'(lfsr_data[3:0]), 32'(ref_seq[i]));
            check($sformatf("seq_ch1_%0d", i), 32'(lfsr_data[7:4]), 32'(ref_seq[i]));
            check($sformatf("seq_wrap_%0d", i), 32'(wrap), (i == 14) ? 32'd3 : 32'd0);
        end
        enable = 1'b0;
        tick();
        check("wrap_one_cycle", 32'(wrap), 32'd0);

        // Table-driven draws.
        for (int v = 0; v < 10; v++) begin
            load_seed(vecs[v].seed);
            check($sformatf("v%0d_ch0_load", v), 32'(lfsr_data[3:0]), 32'(vecs[v].exp_ch0));
            check($sformatf("v%0d_ch1_load", v), 32'(lfsr_data[7:4]), 32'(vecs[v].exp_ch1));
            send_req(vecs[v].ch, vecs[v].range_v);
            check($sformatf("v%0d_ready_low", v), 32'(bus.o_Req_Ready), 32'd0);
            wait_rsp(lat);
            check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("v%0d_data", v), 32'(bus.o_Rsp_Data), 32'(vecs[v].exp_data));
            check($sformatf("v%0d_rsp_ch", v), 32'(bus.o_Rsp_Ch), 32'(vecs[v].ch));
            st = vecs[v].ch ? lfsr_data[7:4] : lfsr_data[3:0];
            check($sformatf("v%0d_final", v), 32'(st), 32'(vecs[v].exp_final));
            finish_rsp();
        end

        // Response held stable through backpressure and a seed load.
        load_seed(4'hE);
        send_req(1'b0, 4'd5);
        wait_rsp(lat);
        check("hold_latency", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                load_seed(4'h5);
            end else begin
                tick();
            end
            check($sformatf("hold_valid_%0d", i), 32'(bus.o_Rsp_Valid), 32'd1);
            check($sformatf("hold_data_%0d", i), 32'(bus.o_Rsp_Data), 32'd3);
            check($sformatf("hold_ch_%0d", i), 32'(bus.o_Rsp_Ch), 32'd0);
            check($sformatf("hold_ready_%0d", i), 32'(bus.o_Req_Ready), 32'd0);
        end
        check("hold_seed_loaded", 32'(lfsr_data[3:0]), 32'h5);
        finish_rsp();

        // Free-run enable during DRAW: still exactly one step per cycle.
        load_seed(4'hE);
        enable = 1'b1;
        send_req(1'b0, 4'd5);
        check("en_step_accept", 32'(lfsr_data[3:0]), 32'hD);
        tick();
        check("en_step_reject", 32'(lfsr_data[3:0]), 32'hB);
        check("en_not_valid", 32'(bus.o_Rsp_Valid), 32'd0);
        enable = 1'b0;
        tick();
        check("en_valid", 32'(bus.o_Rsp_Valid), 32'd1);
        check("en_data", 32'(bus.o_Rsp_Data), 32'd3);
        check("en_final", 32'(lfsr_data[3:0]), 32'h6);
        finish_rsp();

        // Leave a non-zero response behind on ch1, then reset mid-DRAW.
        load_seed(4'h8);
        send_req(1'b1, 4'd4);
        wait_rsp(lat);
        finish_rsp();
        load_seed(4'hE);
        send_req(1'b0, 4'd5);
        tick();
        check("pre_rst_busy", 32'(bus.o_Req_Ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", 32'(bus.o_Req_Ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(bus.o_Rsp_Valid), 32'd0);
        check("mid_rst_rsp_data",  32'(bus.o_Rsp_Data), 32'd0);
        check("mid_rst_rsp_ch",    32'(bus.o_Rsp_Ch), 32'd0);
        check("mid_rst_wrap",      32'(wrap), 32'd0);
        check("mid_rst_lfsr",      32'(lfsr_data), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_req(1'b0, 4'd0);
        wait_rsp(lat);
        check("post_rst_latency", 32'(lat), 32'd1);
        check("post_rst_data", 32'(bus.o_Rsp_Data), 32'd0);
        check("post_rst_final", 32'(lfsr_data[3:0]), 32'h1);
        finish_rsp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
